// File: rtl/vdp2_vram_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : vdp2_vram_sched_if
// Description : Bundle of the VDP2 per-bank VRAM scheduler signals. Names
//               carry the i_/o_ direction of the scheduler itself.
//               slave  : the scheduler (vdp2_vram_sched).
//               master : the surroundings (fetch logic, CPU port, VRAM bank).
//               Groups : slot control (ce_r, slot_res, blank, cyc_pat, slot),
//                        fetch port (fetch_en, fa, fd, fd_valid, fd_id),
//                        CPU port (cpu_req/we/a/d/be, cpu_ack, cpu_q),
//                        VRAM port (ra_a, ra_d, ra_we, ra_be, ra_q).
// Revision    : 1.0  initial release
// ============================================================================
interface vdp2_vram_sched_if #(
    parameter int AW = 19,
    parameter int DW = 16
);
    // slot control
    logic              i_ce_r;
    logic              i_slot_res;
    logic              i_blank;
    logic [31:0]       i_cyc_pat;
    logic [2:0]        o_slot;
    // background fetch port
    logic [7:0]        i_fetch_en;
    logic [8*AW-1:0]   i_fa;
    logic [DW-1:0]     o_fd;
    logic              o_fd_valid;
    logic [2:0]        o_fd_id;
    // CPU port
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [AW-1:0]     i_cpu_a;
    logic [DW-1:0]     i_cpu_d;
    logic [1:0]        i_cpu_be;
    logic              o_cpu_ack;
    logic [DW-1:0]     o_cpu_q;
    // VRAM bank port
    logic [AW-1:0]     o_ra_a;
    logic [DW-1:0]     o_ra_d;
    logic              o_ra_we;
    logic [1:0]        o_ra_be;
    logic [DW-1:0]     i_ra_q;

    modport slave (
        input  i_ce_r, i_slot_res, i_blank, i_cyc_pat,
        input  i_fetch_en, i_fa,
        input  i_cpu_req, i_cpu_we, i_cpu_a, i_cpu_d, i_cpu_be,
        input  i_ra_q,
        output o_slot, o_fd, o_fd_valid, o_fd_id,
        output o_cpu_ack, o_cpu_q,
        output o_ra_a, o_ra_d, o_ra_we, o_ra_be
    );

    modport master (
        output i_ce_r, i_slot_res, i_blank, i_cyc_pat,
        output i_fetch_en, i_fa,
        output i_cpu_req, i_cpu_we, i_cpu_a, i_cpu_d, i_cpu_be,
        output i_ra_q,
        input  o_slot, o_fd, o_fd_valid, o_fd_id,
        input  o_cpu_ack, o_cpu_q,
        input  o_ra_a, o_ra_d, o_ra_we, o_ra_be
    );
endinterface
`default_nettype wire

// File: rtl/vdp2_vram_sched.sv
`default_nettype none
// ============================================================================
// Module      : vdp2_vram_sched
// Description : Per-bank VRAM access scheduler for VDP2. VRAM time is split
//               into eight slots; a 32-bit cycle pattern gives each slot to a
//               background fetch ID (0-7), to the CPU (E/F) or to idle
//               (8-D). BLANK hands every slot to the CPU. Reads return one
//               slot after issue to the owner latched at issue time.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - vdp2_vram_sched_if.slave (slot control, fetch port,
//                        CPU port, VRAM port)
// Parameters  : AW - VRAM word-address width, DW - VRAM data width
// Revision    : 1.0  initial release
// ============================================================================
module vdp2_vram_sched #(
    parameter int AW = 19,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vdp2_vram_sched_if.slave        bus
);

    // Owner of the read currently in flight. A read is always captured on
    // the very next CE_R edge, so at most one can be outstanding.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_CPU   = 2'd2
    } rd_state_t;

    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_nxt;

    logic [2:0]        r_slot,     w_slot_nxt;
    logic [2:0]        r_rd_id,    w_rd_id_nxt;
    logic [AW-1:0]     r_ra_a,     w_ra_a_nxt;
    logic [DW-1:0]     r_ra_d,     w_ra_d_nxt;
    logic              r_ra_we,    w_ra_we_nxt;
    logic [1:0]        r_ra_be,    w_ra_be_nxt;
    logic [DW-1:0]     r_fd,       w_fd_nxt;
    logic              r_fd_valid, w_fd_valid_nxt;
    logic [2:0]        r_fd_id,    w_fd_id_nxt;
    logic              r_cpu_ack,  w_cpu_ack_nxt;
    logic [DW-1:0]     r_cpu_q,    w_cpu_q_nxt;

    // Slot decode, done for the slot being entered on this CE_R edge
    logic [2:0]        w_slot_adv;
    logic [3:0]        w_code;
    logic [AW-1:0]     w_fa_sel;
    logic              w_cpu_slot;
    logic              w_fetch_issue;
    logic              w_cpu_issue;

    always_comb begin
        w_slot_adv = bus.i_slot_res ? 3'd0 : r_slot + 3'd1;

        // Slot 0 lives in the most significant nibble of the pattern
        case (w_slot_adv)
            3'd0:    w_code = bus.i_cyc_pat[31:28];
            3'd1:    w_code = bus.i_cyc_pat[27:24];
            3'd2:    w_code = bus.i_cyc_pat[23:20];
            3'd3:    w_code = bus.i_cyc_pat[19:16];
            3'd4:    w_code = bus.i_cyc_pat[15:12];
            3'd5:    w_code = bus.i_cyc_pat[11:8];
            3'd6:    w_code = bus.i_cyc_pat[7:4];
            default: w_code = bus.i_cyc_pat[3:0];
        endcase

        w_fa_sel      = bus.i_fa[int'(w_code[2:0]) * AW +: AW];
        w_cpu_slot    = bus.i_blank || (w_code[3:1] == 3'b111);
        w_fetch_issue = !bus.i_blank && !w_code[3] && bus.i_fetch_en[w_code[2:0]];

        // A CPU read still awaiting capture blocks the CPU port, and a request
        // seen while ACK is high is the one just completed, not a new one.
        w_cpu_issue   = w_cpu_slot && bus.i_cpu_req &&
                        (r_rd_state != RD_CPU) && !r_cpu_ack;
    end

    // Next-state / output logic
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_slot_nxt     = r_slot;
        w_rd_id_nxt    = r_rd_id;
        w_ra_a_nxt     = r_ra_a;
        w_ra_d_nxt     = r_ra_d;
        w_ra_we_nxt    = r_ra_we;
        w_ra_be_nxt    = r_ra_be;
        w_fd_nxt       = r_fd;
        w_fd_id_nxt    = r_fd_id;
        w_cpu_q_nxt    = r_cpu_q;
        w_fd_valid_nxt = 1'b0;     // pulses last exactly one CLK
        w_cpu_ack_nxt  = 1'b0;

        if (bus.i_ce_r) begin
            w_slot_nxt     = w_slot_adv;
            w_ra_we_nxt    = 1'b0;
            w_rd_state_nxt = RD_IDLE;

            // Capture the read issued on the previous CE_R edge
            case (r_rd_state)
                RD_FETCH: begin
                    w_fd_nxt       = bus.i_ra_q;
                    w_fd_id_nxt    = r_rd_id;
                    w_fd_valid_nxt = 1'b1;
                end
                RD_CPU: begin
                    w_cpu_q_nxt    = bus.i_ra_q;
                    w_cpu_ack_nxt  = 1'b1;
                end
                default: ;
            endcase

            // Issue for the slot being entered; may share the edge with the
            // capture above, which keeps consecutive reads fully pipelined.
            if (w_fetch_issue) begin
                w_ra_a_nxt     = w_fa_sel;
                w_rd_id_nxt    = w_code[2:0];
                w_rd_state_nxt = RD_FETCH;
            end else if (w_cpu_issue) begin
                w_ra_a_nxt  = bus.i_cpu_a;
                w_ra_d_nxt  = bus.i_cpu_d;
                w_ra_be_nxt = bus.i_cpu_be;
                w_ra_we_nxt = bus.i_cpu_we;
                if (bus.i_cpu_we) begin
                    w_cpu_ack_nxt = 1'b1;   // writes complete on the issue edge
                end else begin
                    w_rd_state_nxt = RD_CPU;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_slot     <= 3'd0;
            r_rd_id    <= 3'd0;
            r_ra_a     <= '0;
            r_ra_d     <= '0;
            r_ra_we    <= 1'b0;
            r_ra_be    <= 2'b00;
            r_fd       <= '0;
            r_fd_valid <= 1'b0;
            r_fd_id    <= 3'd0;
            r_cpu_ack  <= 1'b0;
            r_cpu_q    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_slot     <= w_slot_nxt;
            r_rd_id    <= w_rd_id_nxt;
            r_ra_a     <= w_ra_a_nxt;
            r_ra_d     <= w_ra_d_nxt;
            r_ra_we    <= w_ra_we_nxt;
            r_ra_be    <= w_ra_be_nxt;
            r_fd       <= w_fd_nxt;
            r_fd_valid <= w_fd_valid_nxt;
            r_fd_id    <= w_fd_id_nxt;
            r_cpu_ack  <= w_cpu_ack_nxt;
            r_cpu_q    <= w_cpu_q_nxt;
        end
    end

    assign bus.o_slot     = r_slot;
    assign bus.o_ra_a     = r_ra_a;
    assign bus.o_ra_d     = r_ra_d;
    assign bus.o_ra_we    = r_ra_we;
    assign bus.o_ra_be    = r_ra_be;
    assign bus.o_fd       = r_fd;
    assign bus.o_fd_valid = r_fd_valid;
    assign bus.o_fd_id    = r_fd_id;
    assign bus.o_cpu_ack  = r_cpu_ack;
    assign bus.o_cpu_q    = r_cpu_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp2_vram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp2_vram_sched
// Description : Self-checking bench for vdp2_vram_sched. A slot-level model
//               (slot owner lookup, queue of reads in flight, shadow memory)
//               predicts every output each CLK; directed scenarios add
//               hand-computed expectations. CE_R runs at half rate so the
//               synchronous VRAM model returns data in time.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vdp2_vram_sched;
    localparam int AW = 19;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   fdv_cnt  = 0;
    int   ack_cnt  = 0;

    always #5 clk = ~clk;

    vdp2_vram_sched_if #(.AW(AW), .DW(DW)) bus ();
    vdp2_vram_sched #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                            input logic [1:0] be);
        return {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
    endfunction

    // ---------------- VRAM bank: synchronous read, byte-masked write -------
    logic [DW-1:0] ram_w [logic [AW-1:0]];
    always @(posedge clk) begin : vram
        logic [DW-1:0] cur;
        cur = ram_w.exists(bus.o_ra_a) ? ram_w[bus.o_ra_a] : init_val(bus.o_ra_a);
        if (bus.o_ra_we === 1'b1) begin
            cur = merge(cur, bus.o_ra_d, bus.o_ra_be);
            ram_w[bus.o_ra_a] = cur;
        end
        bus.i_ra_q <= cur;
    end

    // ---------------- Slot-level reference model ---------------------------
    // Owner of slot s: -1 idle, 0..7 fetch ID, 8 CPU
    function automatic int slot_owner(input logic [31:0] pat, input int s,
                                      input logic blank, input logic [7:0] en);
        int code;
        code = int'((pat >> (28 - 4 * s)) & 32'hF);
        if (blank) return 8;
        if (code >= 14) return 8;
        if (code < 8) return en[code] ? code : -1;
        return -1;
    endfunction

    int            m_slot     = 0;
    logic [AW-1:0] e_ra_a     = '0;
    logic [DW-1:0] e_ra_d     = '0;
    logic          e_ra_we    = 1'b0;
    logic [1:0]    e_ra_be    = 2'b00;
    logic [DW-1:0] e_fd       = '0;
    logic          e_fd_valid = 1'b0;
    logic [2:0]    e_fd_id    = 3'd0;
    logic          e_ack      = 1'b0;
    logic [DW-1:0] e_cpu_q    = '0;
    int            pq_own[$];
    logic [AW-1:0] pq_addr[$];
    logic [DW-1:0] mm_w [logic [AW-1:0]];
    int            m_own, m_pop;
    logic          m_prev_ack, m_cpu_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_cur;

    always @(posedge clk) begin : model
        if (!rst_n) begin
            m_slot = 0; e_ra_a = '0; e_ra_d = '0; e_ra_we = 1'b0; e_ra_be = 2'b00;
            e_fd = '0; e_fd_valid = 1'b0; e_fd_id = 3'd0; e_ack = 1'b0; e_cpu_q = '0;
            pq_own.delete(); pq_addr.delete();
        end else if (bus.i_ce_r !== 1'b1) begin
            e_fd_valid = 1'b0;
            e_ack      = 1'b0;
        end else begin
            m_prev_ack = e_ack;
            m_cpu_busy = 1'b0;
            e_fd_valid = 1'b0;
            e_ack      = 1'b0;
            e_ra_we    = 1'b0;
            m_slot     = bus.i_slot_res ? 0 : (m_slot + 1) % 8;
            if (pq_own.size() > 0) begin
                m_pop  = pq_own.pop_front();
                m_addr = pq_addr.pop_front();
                m_cur  = mm_w.exists(m_addr) ? mm_w[m_addr] : init_val(m_addr);
                if (m_pop == 8) begin
                    e_ack = 1'b1; e_cpu_q = m_cur; m_cpu_busy = 1'b1;
                end else begin
                    e_fd_valid = 1'b1; e_fd = m_cur; e_fd_id = 3'(m_pop);
                end
            end
            m_own = slot_owner(bus.i_cyc_pat, m_slot, bus.i_blank, bus.i_fetch_en);
            if (m_own >= 0 && m_own < 8) begin
                e_ra_a = bus.i_fa[m_own*AW +: AW];
                pq_own.push_back(m_own);
                pq_addr.push_back(e_ra_a);
            end else if (m_own == 8 && bus.i_cpu_req && !m_cpu_busy && !m_prev_ack) begin
                e_ra_a  = bus.i_cpu_a;
                e_ra_d  = bus.i_cpu_d;
                e_ra_be = bus.i_cpu_be;
                e_ra_we = bus.i_cpu_we;
                if (bus.i_cpu_we) begin
                    m_cur = mm_w.exists(bus.i_cpu_a) ? mm_w[bus.i_cpu_a] : init_val(bus.i_cpu_a);
                    mm_w[bus.i_cpu_a] = merge(m_cur, bus.i_cpu_d, bus.i_cpu_be);
                    e_ack = 1'b1;
                end else begin
                    pq_own.push_back(8);
                    pq_addr.push_back(bus.i_cpu_a);
                end
            end
        end
    end

    // ---------------- Per-cycle compare ------------------------------------
    always @(posedge clk) begin : compare
        #1;
        chk("slot",     32'(bus.o_slot),     32'(m_slot));
        chk("ra_a",     32'(bus.o_ra_a),     32'(e_ra_a));
        chk("ra_d",     32'(bus.o_ra_d),     32'(e_ra_d));
        chk("ra_we",    32'(bus.o_ra_we),    32'(e_ra_we));
        chk("ra_be",    32'(bus.o_ra_be),    32'(e_ra_be));
        chk("fd_valid", 32'(bus.o_fd_valid), 32'(e_fd_valid));
        chk("fd",       32'(bus.o_fd),       32'(e_fd));
        chk("fd_id",    32'(bus.o_fd_id),    32'(e_fd_id));
        chk("cpu_ack",  32'(bus.o_cpu_ack),  32'(e_ack));
        chk("cpu_q",    32'(bus.o_cpu_q),    32'(e_cpu_q));
        if (bus.o_fd_valid === 1'b1) fdv_cnt++;
        if (bus.o_cpu_ack === 1'b1)  ack_cnt++;
    end

    // ---------------- Stimulus helpers -------------------------------------
    // One CE_R edge followed by one idle CLK (half-rate slot clock)
    task automatic slot_step();
        @(negedge clk); bus.i_ce_r = 1'b1;
        @(negedge clk); bus.i_ce_r = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] be, input bit res_first,
                          output int nsteps, output int ack_slot,
                          output logic [DW-1:0] q, output logic we_at_ack);
        bit done = 1'b0;
        nsteps = 0; ack_slot = -1; q = '0; we_at_ack = 1'b0;
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_a = a;
        bus.i_cpu_d = d; bus.i_cpu_be = be;
        if (res_first) bus.i_slot_res = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            slot_step();
            bus.i_slot_res = 1'b0;
            nsteps++;
            if (bus.o_cpu_ack === 1'b1) begin
                done      = 1'b1;
                ack_slot  = int'(bus.o_slot);
                q         = bus.o_cpu_q;
                we_at_ack = bus.o_ra_we;
            end
        end
        bus.i_cpu_req = 1'b0;
        if (!done) chk("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed scenarios -----------------------------------
    initial begin : stim
        int            ns, as, c0, a0;
        logic [DW-1:0] q;
        logic          wa;
        bit            found;

        bus.i_ce_r = 1'b0; bus.i_slot_res = 1'b0; bus.i_blank = 1'b0;
        bus.i_cyc_pat = 32'h0; bus.i_fetch_en = 8'h00;
        bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_a = '0;
        bus.i_cpu_d = '0; bus.i_cpu_be = 2'b00;
        for (int i = 0; i < 8; i++) bus.i_fa[i*AW +: AW] = AW'(i * 256);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_slot",  32'(bus.o_slot),     32'd0);
        chk("rst_ra_a",  32'(bus.o_ra_a),     32'd0);
        chk("rst_ra_we", 32'(bus.o_ra_we),    32'd0);
        chk("rst_fdv",   32'(bus.o_fd_valid), 32'd0);
        chk("rst_ack",   32'(bus.o_cpu_ack),  32'd0);
        rst_n = 1'b1;
        slot_step();
        chk("first_slot_after_reset", 32'(bus.o_slot), 32'd1);

        // Fetch sweep: pattern 01234567, FA[i] = 0x100*i
        bus.i_cyc_pat = 32'h0123_4567; bus.i_fetch_en = 8'hFF;
        bus.i_slot_res = 1'b1; slot_step(); bus.i_slot_res = 1'b0;
        chk("sweep_slot0", 32'(bus.o_slot), 32'd0);
        chk("sweep_ra_a0", 32'(bus.o_ra_a), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            slot_step();
            chk("sweep_ra_a",  32'(bus.o_ra_a),     32'((i % 8) * 256));
            chk("sweep_ra_we", 32'(bus.o_ra_we),    32'd0);
            chk("sweep_fdv",   32'(bus.o_fd_valid), 32'd1);
            chk("sweep_fd_id", 32'(bus.o_fd_id),    32'(i - 1));
            chk("sweep_fd",    32'(bus.o_fd),       32'(16'((i - 1) * 256) ^ 16'hA5A5));
        end

        // CPU write then read back, all slots CPU
        bus.i_cyc_pat = 32'hFFFF_FFFF;
        slot_step();
        cpu_op(1'b1, 19'h12345, 16'hBEEF, 2'b11, 1'b0, ns, as, q, wa);
        chk("wr_ack_steps", 32'(ns), 32'd1);
        chk("wr_we_at_ack", 32'(wa), 32'd1);
        slot_step();
        chk("wr_we_cleared", 32'(bus.o_ra_we), 32'd0);
        cpu_op(1'b0, 19'h12345, 16'h0000, 2'b11, 1'b0, ns, as, q, wa);
        chk("rd_ack_steps", 32'(ns), 32'd2);
        chk("rd_q",         32'(q),  32'h0000_BEEF);

        // CPU read held from slot 0 with pattern 0123EEEE
        bus.i_cyc_pat = 32'h0123_EEEE;
        cpu_op(1'b0, 19'h00777, 16'h0000, 2'b11, 1'b1, ns, as, q, wa);
        chk("late_rd_steps",    32'(ns), 32'd6);
        chk("late_rd_ack_slot", 32'(as), 32'd5);
        chk("late_rd_q",        32'(q),  32'h0000_A2D2);

        // BLANK: everything is CPU, no fetch data
        bus.i_blank = 1'b1; bus.i_cyc_pat = 32'h0;
        slot_step();
        c0 = fdv_cnt;
        cpu_op(1'b1, 19'h00040, 16'h1234, 2'b01, 1'b0, ns, as, q, wa);
        chk("blank_wr_steps", 32'(ns), 32'd1);
        slot_step();
        cpu_op(1'b0, 19'h00040, 16'h0000, 2'b11, 1'b0, ns, as, q, wa);
        chk("blank_rd_q", 32'(q), 32'h0000_A534);
        repeat (4) slot_step();
        chk("blank_no_fdv", 32'(fdv_cnt - c0), 32'd0);

        // SLOT_RES at slot 5
        bus.i_blank = 1'b0; bus.i_cyc_pat = 32'hFFFF_FFFF;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.o_slot == 3'd5) found = 1'b1;
            else slot_step();
        end
        chk("reach_slot5", 32'(found), 32'd1);
        bus.i_slot_res = 1'b1; slot_step(); bus.i_slot_res = 1'b0;
        chk("slot_res_to_0", 32'(bus.o_slot), 32'd0);

        // Reset with a CPU read in flight
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_a = 19'h12345;
        slot_step();
        chk("inflight_ra_a", 32'(bus.o_ra_a),    32'h12345);
        chk("inflight_ack",  32'(bus.o_cpu_ack), 32'd0);
        a0 = ack_cnt; c0 = fdv_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_slot",  32'(bus.o_slot),    32'd0);
        chk("midrst_ra_a",  32'(bus.o_ra_a),    32'd0);
        chk("midrst_ra_d",  32'(bus.o_ra_d),    32'd0);
        chk("midrst_ra_be", 32'(bus.o_ra_be),   32'd0);
        chk("midrst_fd",    32'(bus.o_fd),      32'd0);
        chk("midrst_cpu_q", 32'(bus.o_cpu_q),   32'd0);
        bus.i_cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slot_step();
        slot_step();
        chk("post_rst_slot", 32'(bus.o_slot),     32'd2);
        chk("post_rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        chk("post_rst_no_fdv", 32'(fdv_cnt - c0), 32'd0);

        // Disabled fetch ID 3
        bus.i_cyc_pat = 32'h3333_3333; bus.i_fetch_en = 8'hF7;
        c0 = fdv_cnt;
        for (int i = 0; i < 8; i++) begin
            slot_step();
            chk("fe0_ra_we", 32'(bus.o_ra_we), 32'd0);
        end
        chk("fe0_no_fdv", 32'(fdv_cnt - c0), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
